vram_port_arbiter: RTL
======================

// Module: vram_port_arbiter
// PURPOSE
//  Shares the single host-side VRAM access slot between two requesters: the
//  bus control block (host, port 0) and a fill/scroll engine (eng, port 1).
//  Grants one request per slot, drives the VRAM command bus, returns read
//  data and acknowledges the winner. Sits between control/engine and vram.
// PARAMETERS
//  AW        16  address width (VRAM word address)
//  DW        16  data width (char+attribute word)
//  RD_LAT     2  clocks from mem_valid (read) to mem_rdata valid, 1..7
// PORTS
//  clk        in   1   system clock
//  rst        in   1   asynchronous reset, active-high
//  slot       in   1   1-clk pulse: VRAM host slot free this clock
//  host_req   in   1   host request, held until host_ack
//  host_we    in   1   1=write 0=read
//  host_addr  in   AW  host address
//  host_wdata in   DW  host write data
//  host_ack   out  1   1-clk pulse: host access complete
//  host_rdata out  DW  read data, valid with host_ack on reads
//  eng_req    in   1   engine request, held until eng_ack
//  eng_we     in   1   1=write 0=read
//  eng_addr   in   AW  engine address
//  eng_wdata  in   DW  engine write data
//  eng_ack    out  1   1-clk pulse: engine access complete
//  eng_rdata  out  DW  read data, valid with eng_ack on reads
//  mem_valid  out  1   1-clk command strobe to VRAM
//  mem_we     out  1   write enable qualifying mem_valid
//  mem_addr   out  AW  registered address
//  mem_wdata  out  DW  registered write data
//  mem_rdata  in   DW  VRAM read data, sampled RD_LAT clks after mem_valid
//  busy       out  1   arbiter not in IDLE
// BEHAVIOUR
//  - Reset: all outputs 0, state IDLE, last_grant=eng (host wins first tie).
//  - States: IDLE -> ISSUE -> (write) ACK | (read) WAIT -> ACK -> IDLE.
//  - IDLE: on clk where slot=1 and any req=1, choose winner, latch we/addr/
//    wdata into mem_* regs, go ISSUE. slot ignored when no req; req raised
//    without slot waits for next slot. slot outside IDLE is dropped.
//  - ISSUE: mem_valid=1 exactly one clk. Write -> ACK. Read -> WAIT, load
//    counter with RD_LAT-1.
//  - WAIT: decrement; at 0 capture mem_rdata into winner's rdata reg -> ACK.
//  - ACK: winner's ack=1 one clk, rdata stable from this clk until next
//    ack of same port; update last_grant; -> IDLE. Earliest next issue is
//    the following slot, so a requester never gets two slots back-to-back
//    when the other is waiting (see macro).
//  - Write latency: slot clk +2 to ack. Read: slot clk +2+RD_LAT to ack.
//  - Requester dropping req before ack: access still completes, ack still
//    pulses (protocol violation; arbiter must not hang).
//  - Loser's request stays pending; no inputs are sampled for it until its
//    own grant.
//  - rst mid-access: immediate return to IDLE, acks 0, mem_valid 0; no
//    partial ack after release.
//  - mem_addr/mem_wdata/mem_we hold last values outside ISSUE.
// CONFIGURATION
//  ARB_ROUND_ROBIN_EN defined: tie (both req in same slot) -> port not in
//    last_grant wins; strict alternation under continuous load.
//  ARB_ROUND_ROBIN_EN undefined: fixed priority, host always wins ties;
//    engine served only in slots where host_req=0. last_grant unused.
// TESTING
//  1 host write A=0x0123 D=0xABCD, slot pulse -> mem_valid 1 clk with
//    we=1,addr 0x0123,data 0xABCD; host_ack at slot+2; eng_ack stays 0.
//  2 eng read A=0x0040, mem_rdata=0x5A5A, RD_LAT=2 -> eng_ack at slot+4,
//    eng_rdata=0x5A5A; host_rdata unchanged.
//  3 both req held, 6 slots, RR_EN on -> grants H,E,H,E,H,E; RR_EN off ->
//    H x6, eng_ack never while host_req=1.
//  4 req asserted, no slot for 20 clks -> mem_valid 0, busy 0; first slot
//    -> issue next clk.
//  5 rst asserted in WAIT of a read -> next clk all outputs 0, state IDLE;
//    after release and new slot, pending req reissued and acked once.
//  6 slot pulses every clk during a read -> only one mem_valid per access,
//    extra slots ignored, no lost or duplicate ack.

Source files
------------

// File: rtl/vram_port_arbiter.sv
// rtl/vram_port_arbiter.sv - two-port arbiter for the host VRAM access slot
// Optional round-robin tie break: define ARB_ROUND_ROBIN_EN (default is fixed host priority).
module vram_port_arbiter #(
    parameter int AW     = 16,
    parameter int DW     = 16,
    parameter int RD_LAT = 2
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_slot,
    input  logic          i_host_req,
    input  logic          i_host_we,
    input  logic [AW-1:0] i_host_addr,
    input  logic [DW-1:0] i_host_wdata,
    output logic          o_host_ack,
    output logic [DW-1:0] o_host_rdata,
    input  logic          i_eng_req,
    input  logic          i_eng_we,
    input  logic [AW-1:0] i_eng_addr,
    input  logic [DW-1:0] i_eng_wdata,
    output logic          o_eng_ack,
    output logic [DW-1:0] o_eng_rdata,
    output logic          o_mem_valid,
    output logic          o_mem_we,
    output logic [AW-1:0] o_mem_addr,
    output logic [DW-1:0] o_mem_wdata,
    input  logic [DW-1:0] i_mem_rdata,
    output logic          o_busy
);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_ACK} state_t;

    localparam logic [2:0] CNT_INIT = 3'(RD_LAT - 1);

    state_t     r_state;
    state_t     w_next;
    logic       r_win;
    logic [2:0] r_cnt;
    logic       w_win;
    logic       w_grant;

`ifdef ARB_ROUND_ROBIN_EN
    logic r_last;

    // On a tie the port that was not served last wins.
    always_comb begin
        w_win = ~i_host_req;
        if (i_host_req && i_eng_req) begin
            w_win = ~r_last;
        end
    end
`else
    always_comb begin
        w_win = ~i_host_req;
    end
`endif

    assign w_grant = i_slot & (i_host_req | i_eng_req);
    assign o_busy  = (r_state != S_IDLE);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next      = r_state;
        o_mem_valid = 1'b0;
        o_host_ack  = 1'b0;
        o_eng_ack   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_grant) begin
                    w_next = S_ISSUE;
                end
            end
            S_ISSUE: begin
                o_mem_valid = 1'b1;
                w_next      = o_mem_we ? S_ACK : S_WAIT;
            end
            S_WAIT: begin
                if (r_cnt == 3'd0) begin
                    w_next = S_ACK;
                end
            end
            S_ACK: begin
                o_host_ack = ~r_win;
                o_eng_ack  = r_win;
                w_next     = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_win        <= 1'b0;
            r_cnt        <= 3'd0;
            o_mem_we     <= 1'b0;
            o_mem_addr   <= '0;
            o_mem_wdata  <= '0;
            o_host_rdata <= '0;
            o_eng_rdata  <= '0;
`ifdef ARB_ROUND_ROBIN_EN
            r_last       <= 1'b1;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_grant) begin
                        r_win       <= w_win;
                        o_mem_we    <= w_win ? i_eng_we    : i_host_we;
                        o_mem_addr  <= w_win ? i_eng_addr  : i_host_addr;
                        o_mem_wdata <= w_win ? i_eng_wdata : i_host_wdata;
                    end
                end
                S_ISSUE: begin
                    r_cnt <= CNT_INIT;
                end
                S_WAIT: begin
                    // Captured data becomes visible in the ack cycle and holds until the next read.
                    if (r_cnt == 3'd0) begin
                        if (r_win) begin
                            o_eng_rdata <= i_mem_rdata;
                        end else begin
                            o_host_rdata <= i_mem_rdata;
                        end
                    end else begin
                        r_cnt <= r_cnt - 3'd1;
                    end
                end
                S_ACK: begin
`ifdef ARB_ROUND_ROBIN_EN
                    r_last <= r_win;
`endif
                end
                default: ;
            endcase
        end
    end

endmodule
